// File: rtl/edsac_ctl_pkg.sv
// edsac_ctl_pkg: shared types, defaults and helpers for the EDSAC-style order sequencers
package edsac_ctl_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_RUN
    } state_e;

    typedef enum logic [1:0] {
        ORD_V,
        ORD_N,
        ORD_L,
        ORD_R
    } order_e;

    localparam int DIGITS_DEF    = 36;
    localparam int MUL_STEPS_DEF = 17;
    localparam int CNT_W         = 6;

    // Places to shift: one more than the index of the lowest set bit, 0 for an empty field.
    // Scanning from the top down lets the lowest set bit overwrite any higher one.
    function automatic logic [3:0] shift_places(input logic [10:0] field);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 10; i >= 0; i--)
            if (field[i]) n = 4'(i + 1);
        return n;
    endfunction

endpackage

// File: rtl/digit_timer.sv
// digit_timer: free-running digit counter for one minor cycle with first/last digit strobes
//   clk, rst_n  : clock (one per digit pulse), async active-low reset
//   dig_o       : current digit 0..DIGITS-1
//   d0_o        : high on digit 0 (also throughout reset)
//   dlast_o     : high on digit DIGITS-1
module digit_timer
    import edsac_ctl_pkg::*;
#(
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    output logic [$clog2(DIGITS)-1:0] dig_o,
    output logic                      d0_o,
    output logic                      dlast_o
);

    localparam int DW = $clog2(DIGITS);

    logic [DW-1:0] dig_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) dig_q <= '0;
        else        dig_q <= dlast_o ? '0 : dig_q + 1'b1;

    assign dig_o   = dig_q;
    assign d0_o    = dig_q == '0;
    assign dlast_o = dig_q == DW'(DIGITS - 1);

endmodule

// File: rtl/mul_shift_seq.sv
// mul_shift_seq: sequencer for multiply (V/N) and shift (L/R) orders
//   clk, rst_n        : clock (one per digit), async active-low reset
//   start_i           : order strobe; c14_i=V, c11_i=N, c_l_i=L, c_r_i=R
//   shift_field_i     : address field, lowest set bit selects the shift count
//   mr_bit_i          : multiplier LSB, sampled on the last digit
//   busy_o            : order in progress
//   g5_o              : accumulator shift gate (whole of RUN)
//   add_gate_o        : multiplicand add/subtract enable for this minor cycle
//   sub_mode_o        : latched N order
//   ds_o              : right-shift sign propagation pulse
//   ep_o              : end pulse, on the first digit after the last minor cycle
//   step_o            : minor cycles completed in RUN
//   d0_o, d35_o, dig_o: digit timer outputs
//   start_err_o       : pulse, the clock after a rejected start
module mul_shift_seq
    import edsac_ctl_pkg::*;
#(
    parameter int DIGITS    = DIGITS_DEF,
    parameter int MUL_STEPS = MUL_STEPS_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_i,
    input  logic                      c14_i,
    input  logic                      c11_i,
    input  logic                      c_l_i,
    input  logic                      c_r_i,
    input  logic [10:0]               shift_field_i,
    input  logic                      mr_bit_i,
    output logic                      busy_o,
    output logic                      g5_o,
    output logic                      add_gate_o,
    output logic                      sub_mode_o,
    output logic                      ds_o,
    output logic                      ep_o,
    output logic [CNT_W-1:0]          step_o,
    output logic                      d0_o,
    output logic                      d35_o,
    output logic [$clog2(DIGITS)-1:0] dig_o,
    output logic                      start_err_o
);

    state_e           state_q, state_d;
    order_e           ord_q, ord_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] step_q, step_d;
    logic             add_gate_q, add_gate_d;
    logic             sub_mode_q, sub_mode_d;
    logic             ep_q, ep_d;
    logic             start_err_q, start_err_d;
    logic             d35;
    logic             is_mul;
    logic             valid_start;
    order_e           new_ord;

    digit_timer #(.DIGITS(DIGITS)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .dig_o  (dig_o),
        .d0_o   (d0_o),
        .dlast_o(d35)
    );

    assign d35_o       = d35;
    assign is_mul      = (ord_q == ORD_V) || (ord_q == ORD_N);
    assign valid_start = $onehot({c14_i, c11_i, c_l_i, c_r_i});
    assign new_ord     = c14_i ? ORD_V : c11_i ? ORD_N : c_l_i ? ORD_L : ORD_R;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ord_q       <= ORD_V;
            count_q     <= '0;
            step_q      <= '0;
            add_gate_q  <= 1'b0;
            sub_mode_q  <= 1'b0;
            ep_q        <= 1'b0;
            start_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ord_q       <= ord_d;
            count_q     <= count_d;
            step_q      <= step_d;
            add_gate_q  <= add_gate_d;
            sub_mode_q  <= sub_mode_d;
            ep_q        <= ep_d;
            start_err_q <= start_err_d;
        end

    always_comb begin
        state_d     = state_q;
        ord_d       = ord_q;
        count_d     = count_q;
        step_d      = step_q;
        add_gate_d  = add_gate_q;
        sub_mode_d  = sub_mode_q;
        ep_d        = 1'b0;
        start_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                start_err_d = start_i & ~valid_start;
                if (start_i && valid_start) begin
                    state_d    = S_ARM;
                    ord_d      = new_ord;
                    count_d    = (c14_i | c11_i) ? CNT_W'(MUL_STEPS) : CNT_W'(shift_places(shift_field_i));
                    step_d     = '0;
                    sub_mode_d = c11_i;
                    add_gate_d = 1'b0;
                end
            end
            S_ARM: begin
                start_err_d = start_i;
                // A zero-count order ends here; its ep lands on the next digit 0.
                if (d35) begin
                    state_d    = count_q == '0 ? S_IDLE : S_RUN;
                    ep_d       = count_q == '0;
                    add_gate_d = count_q != '0 && is_mul && mr_bit_i;
                end
            end
            S_RUN: begin
                start_err_d = start_i;
                if (d35) begin
                    count_d    = count_q - 1'b1;
                    step_d     = step_q + 1'b1;
                    state_d    = count_q == CNT_W'(1) ? S_IDLE : S_RUN;
                    ep_d       = count_q == CNT_W'(1);
                    add_gate_d = count_q != CNT_W'(1) && is_mul && mr_bit_i;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o      = state_q != S_IDLE;
        g5_o        = state_q == S_RUN;
        ds_o        = (state_q == S_RUN) && (ord_q == ORD_R) && d35;
        add_gate_o  = add_gate_q;
        sub_mode_o  = sub_mode_q;
        ep_o        = ep_q;
        step_o      = step_q;
        start_err_o = start_err_q;
    end

endmodule

// File: tb/tb_mul_shift_seq.sv
// tb_mul_shift_seq: randomized scoreboard bench for mul_shift_seq
module tb_mul_shift_seq;

    localparam int DIG = 36;
    localparam int MUL = 17;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start_i = 1'b0;
    logic        c14_i = 1'b0, c11_i = 1'b0, c_l_i = 1'b0, c_r_i = 1'b0;
    logic [10:0] shift_field_i = '0;
    logic        mr_bit_i = 1'b0;
    logic        busy_o, g5_o, add_gate_o, sub_mode_o, ds_o, ep_o;
    logic [5:0]  step_o;
    logic        d0_o, d35_o, start_err_o;
    logic [5:0]  dig_o;

    mul_shift_seq #(.DIGITS(DIG), .MUL_STEPS(MUL)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .c14_i        (c14_i),
        .c11_i        (c11_i),
        .c_l_i        (c_l_i),
        .c_r_i        (c_r_i),
        .shift_field_i(shift_field_i),
        .mr_bit_i     (mr_bit_i),
        .busy_o       (busy_o),
        .g5_o         (g5_o),
        .add_gate_o   (add_gate_o),
        .sub_mode_o   (sub_mode_o),
        .ds_o         (ds_o),
        .ep_o         (ep_o),
        .step_o       (step_o),
        .d0_o         (d0_o),
        .d35_o        (d35_o),
        .dig_o        (dig_o),
        .start_err_o  (start_err_o)
    );

    typedef struct {
        int ep_cyc;
        int step;
        int sub;
        int g5n;
        int dsn;
        int addn;
        int busyn;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   e0 = 0;
    int   idle_at = 0;
    int   last_s = 0;
    bit   mr_tab[65536];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // mr_bit for the edge about to come is table-driven so the model can look ahead
    always @(negedge clk) mr_bit_i = mr_tab[cyc];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int dig_at(input int c);
        return (c - e0) % DIG;
    endfunction

    function automatic int places(input logic [10:0] f);
        for (int i = 0; i < 11; i++)
            if (f[i]) return i + 1;
        return 0;
    endfunction

    // Cycle at which RUN begins for a start sampled at cycle s.
    function automatic int run_of(input int s);
        int d;
        d = dig_at(s);
        return s + ((d == DIG - 1) ? DIG : DIG - 1 - d) + 1;
    endfunction

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic go_dig(input int d);
        for (int i = 0; i < DIG && dig_at(cyc) != d; i++) @(negedge clk);
    endtask

    // bits = {c14, c11, c_l, c_r}
    task automatic issue(input logic [3:0] bits, input logic [10:0] f);
        int   s, cnt, run, ones;
        bit   acc, busy_exp;
        exp_t e;
        s = cyc;
        last_s = s;
        chk("dig_model", dig_o, dig_at(s));
        acc = (s >= idle_at) && ($countones(bits) == 1);
        busy_exp = acc || (s + 1 < idle_at);
        {c14_i, c11_i, c_l_i, c_r_i} = bits;
        shift_field_i = f;
        start_i = 1'b1;
        if (acc) begin
            cnt = (bits[3] || bits[2]) ? MUL : places(f);
            run = run_of(s);
            ones = 0;
            if (bits[3] || bits[2])
                for (int j = 0; j < cnt; j++) ones += int'(mr_tab[run - 1 + j * DIG]);
            e.ep_cyc = run + cnt * DIG;
            e.step   = cnt;
            e.sub    = int'(bits[2]);
            e.g5n    = cnt * DIG;
            e.dsn    = bits[0] ? cnt : 0;
            e.addn   = ones * DIG;
            e.busyn  = e.ep_cyc - s - 1;
            idle_at  = e.ep_cyc;
            sbq.push_back(e);
        end
        @(negedge clk);
        start_i = 1'b0;
        {c14_i, c11_i, c_l_i, c_r_i} = 4'b0;
        chk("busy_after_start", busy_o, int'(busy_exp));
        chk("start_err", start_err_o, int'(!acc));
    endtask

    // Monitor: accumulate per-order activity and score it on each end pulse.
    initial begin
        int   g5n, dsn, addn, busyn;
        exp_t e;
        g5n = 0; dsn = 0; addn = 0; busyn = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                g5n = 0; dsn = 0; addn = 0; busyn = 0;
                chk("no_ep_in_reset", ep_o, 0);
            end else begin
                g5n   += int'(g5_o);
                dsn   += int'(ds_o);
                addn  += int'(add_gate_o);
                busyn += int'(busy_o);
                if (ds_o) chk("ds_on_d35", d35_o, 1);
                if (ep_o) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_ep", 1, 0);
                    end else begin
                        e = sbq.pop_front();
                        chk("ep_cycle", cyc, e.ep_cyc);
                        chk("ep_d0", d0_o, 1);
                        chk("ep_busy_low", busy_o, 0);
                        chk("ep_step", step_o, e.step);
                        chk("ep_sub_mode", sub_mode_o, e.sub);
                        chk("g5_clocks", g5n, e.g5n);
                        chk("ds_pulses", dsn, e.dsn);
                        chk("add_gate_clocks", addn, e.addn);
                        chk("busy_clocks", busyn, e.busyn);
                    end
                    g5n = 0; dsn = 0; addn = 0; busyn = 0;
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int s, run;
        logic [3:0]  bits;
        logic [10:0] f;
        for (int i = 0; i < 65536; i++) mr_tab[i] = 1'($urandom);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy_o, 0);
        chk("rst_d0", d0_o, 1);
        chk("rst_dig", dig_o, 0);
        chk("rst_g5", g5_o, 0);
        chk("rst_step", step_o, 0);
        chk("rst_ep", ep_o, 0);
        chk("rst_start_err", start_err_o, 0);
        rst_n = 1'b1;
        e0 = cyc;
        idle_at = cyc;

        // V order from digit 10 with the multiplier LSB always 1
        go_dig(10);
        for (int i = cyc; i < cyc + 700; i++) mr_tab[i] = 1'b1;
        issue(4'b1000, 11'd0);
        s = last_s;
        wait_cyc(s + 25);
        chk("v_g5_before_run", g5_o, 0);
        wait_cyc(s + 26);
        chk("v_g5_run_entry", g5_o, 1);
        chk("v_add_gate", add_gate_o, 1);
        wait_cyc(s + 638);
        chk("v_ep_t638", ep_o, 1);
        chk("v_step17", step_o, 17);

        // N order with the multiplier LSB alternating 1,0,...
        wait_cyc(idle_at + 5);
        go_dig(int'($urandom_range(0, DIG - 1)));
        run = run_of(cyc);
        for (int j = 0; j < MUL; j++) mr_tab[run - 1 + j * DIG] = (j % 2 == 0);
        issue(4'b0100, 11'd0);
        wait_cyc(run + 1);
        chk("n_add_first", add_gate_o, 1);
        chk("n_sub_mode", sub_mode_o, 1);
        wait_cyc(run + DIG + 1);
        chk("n_add_second", add_gate_o, 0);

        // R order, 3 places
        wait_cyc(idle_at + 3);
        go_dig(int'($urandom_range(0, DIG - 1)));
        issue(4'b0001, 11'b000_0000_0100);

        // L order with an empty field, starting at digit 30
        wait_cyc(idle_at);
        go_dig(30);
        issue(4'b0010, 11'd0);
        wait_cyc(last_s + 6);
        chk("l0_ep_t6", ep_o, 1);

        // Rejected starts: two order bits in IDLE, then a V start mid-RUN
        wait_cyc(idle_at + 2);
        issue(4'b1001, 11'd0);
        chk("bad_start_idle", busy_o, 0);
        issue(4'b1000, 11'd0);
        wait_cyc(last_s + 100);
        issue(4'b1000, 11'd0);

        // Next order accepted in the ep clock
        wait_cyc(idle_at);
        issue(4'b0001, 11'b100_0000_0000);

        // Start on the last digit waits a full minor cycle
        wait_cyc(idle_at);
        go_dig(DIG - 1);
        issue(4'b0010, 11'b000_0000_0011);

        // Random orders
        for (int k = 0; k < 14; k++) begin
            wait_cyc(idle_at);
            if ($urandom_range(0, 2) != 0) go_dig(int'($urandom_range(0, DIG - 1)));
            bits = ($urandom_range(0, 9) < 4) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            f = ($urandom_range(0, 4) == 0) ? 11'd0 : 11'($urandom);
            issue(bits, f);
            if ($urandom_range(0, 2) == 0 && cyc + 5 < idle_at) begin
                wait_cyc(cyc + 3);
                issue(4'($urandom_range(0, 15)), 11'($urandom));
            end
        end

        // Asynchronous reset in the middle of a multiply
        wait_cyc(idle_at);
        issue(4'b0100, 11'd0);
        wait_cyc(last_s + 200);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy_o, 0);
        chk("abort_g5", g5_o, 0);
        chk("abort_add_gate", add_gate_o, 0);
        chk("abort_sub_mode", sub_mode_o, 0);
        chk("abort_step", step_o, 0);
        chk("abort_dig", dig_o, 0);
        chk("abort_d0", d0_o, 1);
        sbq.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        e0 = cyc;
        idle_at = cyc;
        go_dig(int'($urandom_range(0, DIG - 1)));
        issue(4'b0010, 11'b000_0001_0000);

        wait_cyc(idle_at + 40);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
